// File: rtl/hockey_ssd_scanner.sv
// Air-hockey 8-digit multiplexed common-anode 7-segment scanner; inputs are snapshotted once per scan frame.
// Optional serve-indicator decimal point (turn/dp ports) is built when HOCKEY_SSD_DP_EN is defined.
module hockey_ssd_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic [2:0] x_coord,
  input  logic [2:0] y_coord,
  input  logic [1:0] score_a,
  input  logic [1:0] score_b,
  input  logic       winner,
`ifdef HOCKEY_SSD_DP_EN
  input  logic [1:0] turn,
  output logic       dp,
`endif
  output logic [7:0] an,
  output logic [6:0] seg
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] P_TC = PW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] F_TC = FW'(BLINK_FRAMES - 1);

  localparam logic [6:0] G_0     = 7'h40;
  localparam logic [6:0] G_1     = 7'h79;
  localparam logic [6:0] G_2     = 7'h24;
  localparam logic [6:0] G_3     = 7'h30;
  localparam logic [6:0] G_DASH  = 7'h3F;
  localparam logic [6:0] G_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_PLAY = 2'd1,
    M_GOAL = 2'd2,
    M_OVER = 2'd3
  } mode_t;

  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;
  logic          r_step;
  logic [FW-1:0] r_fcnt;
  logic          r_phase;

  mode_t         r_snap_mode;
  logic [2:0]    r_snap_x;
  logic [2:0]    r_snap_y;
  logic [1:0]    r_snap_sa;
  logic [1:0]    r_snap_sb;
  logic          r_snap_win;

  logic          w_tc;
  logic          w_wrap;
  logic [6:0]    w_seg;
  logic [2:0]    w_win_digit;

  assign w_tc        = (r_presc == P_TC);
  assign w_wrap      = w_tc && (r_idx == 3'd7);
  assign w_win_digit = r_snap_win ? 3'd0 : 3'd7;

  function automatic logic [6:0] f_glyph(input logic [1:0] v);
    case (v)
      2'd0:    f_glyph = G_0;
      2'd1:    f_glyph = G_1;
      2'd2:    f_glyph = G_2;
      default: f_glyph = G_3;
    endcase
  endfunction

  // Scan timebase: the registered step flag lets an/seg follow the index one clock later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= 3'd0;
      r_step  <= 1'b0;
    end else begin
      r_step <= w_tc;
      if (w_tc) begin
        r_presc <= '0;
        r_idx   <= r_idx + 3'd1;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap_mode <= M_IDLE;
      r_snap_x    <= 3'd0;
      r_snap_y    <= 3'd0;
      r_snap_sa   <= 2'd0;
      r_snap_sb   <= 2'd0;
      r_snap_win  <= 1'b0;
      r_fcnt      <= '0;
      r_phase     <= 1'b1;
    end else if (w_wrap) begin
      r_snap_mode <= mode_t'(mode);
      r_snap_x    <= x_coord;
      r_snap_y    <= y_coord;
      r_snap_sa   <= score_a;
      r_snap_sb   <= score_b;
      r_snap_win  <= winner;
      // A mode change restarts the blink so a new GOAL/OVER screen always opens lit.
      if (mode_t'(mode) != r_snap_mode) begin
        r_fcnt  <= '0;
        r_phase <= 1'b1;
      end else if (r_fcnt == F_TC) begin
        r_fcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_fcnt <= r_fcnt + FW'(1);
      end
    end
  end

  always_comb begin
    w_seg = G_BLANK;
    case (r_snap_mode)
      M_IDLE: w_seg = G_DASH;
      M_PLAY: begin
        if (r_idx == r_snap_x) begin
          case (r_snap_y)
            3'd0:    w_seg = 7'h7E;
            3'd1:    w_seg = 7'h7D;
            3'd2:    w_seg = 7'h3F;
            3'd3:    w_seg = 7'h7B;
            3'd4:    w_seg = 7'h77;
            default: w_seg = G_BLANK;
          endcase
        end
      end
      default: begin
        case (r_idx)
          3'd7:       w_seg = f_glyph(r_snap_sa);
          3'd0:       w_seg = f_glyph(r_snap_sb);
          3'd4, 3'd3: w_seg = G_DASH;
          default:    w_seg = G_BLANK;
        endcase
        // GOAL blinks the whole bank; OVER blinks only the winner's score digit.
        if (!r_phase && ((r_snap_mode == M_GOAL) || (r_idx == w_win_digit))) begin
          w_seg = G_BLANK;
        end
      end
    endcase
  end

`ifdef HOCKEY_SSD_DP_EN
  logic [1:0] r_snap_turn;
  logic       w_dp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap_turn <= 2'b00;
    end else if (w_wrap) begin
      r_snap_turn <= turn;
    end
  end

  always_comb begin
    w_dp = 1'b1;
    if ((r_snap_mode == M_IDLE) || (r_snap_mode == M_PLAY)) begin
      if (((r_idx == 3'd7) && (r_snap_turn == 2'b01)) ||
          ((r_idx == 3'd0) && (r_snap_turn == 2'b10))) begin
        w_dp = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp <= 1'b1;
    end else if (r_step) begin
      dp <= w_dp;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 8'hFF;
      seg <= G_BLANK;
    end else if (r_step) begin
      an  <= ~(8'h01 << r_idx);
      seg <= w_seg;
    end
  end

endmodule

// File: tb/tb_hockey_ssd_scanner.sv
// Self-checking bench for hockey_ssd_scanner: frame-level behavioural model checked every cycle plus literal pins.
module tb_hockey_ssd_scanner;

  localparam int RD = 4;
  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [2:0] x_coord = 3'd0;
  logic [2:0] y_coord = 3'd0;
  logic [1:0] score_a = 2'd0;
  logic [1:0] score_b = 2'd0;
  logic       winner = 1'b0;
  logic [1:0] turn = 2'b00;
  logic       dp;
  logic [7:0] an;
  logic [6:0] seg;

  int vectors = 0;
  int miscompares = 0;

`ifndef HOCKEY_SSD_DP_EN
  assign dp = 1'b1;
`endif

  hockey_ssd_scanner #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .x_coord(x_coord),
    .y_coord(y_coord),
    .score_a(score_a),
    .score_b(score_b),
    .winner(winner),
`ifdef HOCKEY_SSD_DP_EN
    .turn(turn),
    .dp(dp),
`endif
    .an(an),
    .seg(seg)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int         n;
  int         k;
  logic [1:0] s_mode;
  int         s_x, s_y;
  logic [1:0] s_sa, s_sb;
  logic       s_win;
  logic [1:0] s_turn;
  logic [7:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  function automatic logic [6:0] glyph(input logic [1:0] v);
    case (v)
      2'd0:    return 7'h40;
      2'd1:    return 7'h79;
      2'd2:    return 7'h24;
      default: return 7'h30;
    endcase
  endfunction

  function automatic logic [6:0] model_seg(input int d, input logic [1:0] m, input int x, input int y,
                                           input logic [1:0] sa, input logic [1:0] sb, input logic w,
                                           input bit on);
    logic [6:0] g;
    g = 7'h7F;
    if (m == 2'd0) return 7'h3F;
    if (m == 2'd1) begin
      if (d != x) return 7'h7F;
      case (y)
        0: return 7'h7E;
        1: return 7'h7D;
        2: return 7'h3F;
        3: return 7'h7B;
        4: return 7'h77;
        default: return 7'h7F;
      endcase
    end
    if (d == 7) g = glyph(sa);
    else if (d == 0) g = glyph(sb);
    else if (d == 4 || d == 3) g = 7'h3F;
    if (!on) begin
      if (m == 2'd2) g = 7'h7F;
      else if (d == (w ? 0 : 7)) g = 7'h7F;
    end
    return g;
  endfunction

  task automatic reset_model();
    n = 0; k = 0;
    s_mode = 2'd0; s_x = 0; s_y = 0; s_sa = 2'd0; s_sb = 2'd0; s_win = 1'b0; s_turn = 2'b00;
    exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1;
  endtask

  initial begin
    int d;
    reset_model();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        reset_model();
      end else begin
        n++;
        if (n % (RD * 8) == 0) begin
          if (mode != s_mode) k = 0;
          else k++;
          s_mode = mode; s_x = int'(x_coord); s_y = int'(y_coord);
          s_sa = score_a; s_sb = score_b; s_win = winner; s_turn = turn;
        end
        if (n > RD && (n - 1) % RD == 0) begin
          d = ((n - 1) / RD) % 8;
          exp_an  = ~(8'h01 << d);
          exp_seg = model_seg(d, s_mode, s_x, s_y, s_sa, s_sb, s_win, ((k / BF) % 2) == 0);
          exp_dp  = 1'b1;
`ifdef HOCKEY_SSD_DP_EN
          if ((s_mode == 2'd0 || s_mode == 2'd1) &&
              ((d == 7 && s_turn == 2'b01) || (d == 0 && s_turn == 2'b10))) exp_dp = 1'b0;
`endif
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("model_an", an, exp_an);
      chk("model_seg", {1'b0, seg}, {1'b0, exp_seg});
      chk("model_dp", {7'd0, dp}, {7'd0, exp_dp});
    end
  end

  task automatic lit(input string name, input logic [7:0] a, input logic [6:0] s);
    chk({name, "_an"}, an, a);
    chk({name, "_seg"}, {1'b0, seg}, {1'b0, s});
  endtask

  task automatic wait_an(input logic [7:0] target);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (an == target) found = 1'b1;
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_an: an=%h never reached %h at %0t", an, target, $time);
    end
  endtask

  logic [6:0] goal_d0 [4] = '{7'h79, 7'h79, 7'h7F, 7'h7F};
  logic [6:0] goal_d7 [4] = '{7'h24, 7'h24, 7'h7F, 7'h7F};
  logic [6:0] goal_d3 [4] = '{7'h3F, 7'h3F, 7'h7F, 7'h7F};
  logic [6:0] over_d0 [5] = '{7'h30, 7'h30, 7'h7F, 7'h7F, 7'h30};

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    lit("reset_hold", 8'hFF, 7'h7F);
    rst = 1'b0;
    @(negedge clk);
    lit("reset_rel", 8'hFF, 7'h7F);

    // walk through the reset-snapshot (IDLE) frame
    for (int d = 1; d < 8; d++) begin
      wait_an(~(8'h01 << d));
      lit("idle_walk", ~(8'h01 << d), 7'h3F);
    end
    mode = 2'd1; x_coord = 3'd3; y_coord = 3'd2;
    wait_an(8'hFE);
    lit("play_d0", 8'hFE, 7'h7F);
    wait_an(8'hF7);
    lit("play_x3y2", 8'hF7, 7'h3F);
    wait_an(8'hEF);
    lit("play_d4", 8'hEF, 7'h7F);

    y_coord = 3'd5;
    wait_an(8'hFE);
    wait_an(8'hF7);
    lit("play_y5", 8'hF7, 7'h7F);

    // no tearing: x moves while digit 2 is lit
    y_coord = 3'd2;
    wait_an(8'hFE);
    wait_an(8'hFB);
    x_coord = 3'd5;
    wait_an(8'hF7);
    lit("tear_old_x", 8'hF7, 7'h3F);
    wait_an(8'hDF);
    lit("tear_d5_blank", 8'hDF, 7'h7F);
    wait_an(8'hFE);
    wait_an(8'hDF);
    lit("tear_d5_next", 8'hDF, 7'h3F);

    wait_an(8'h7F);
    mode = 2'd2; score_a = 2'd2; score_b = 2'd1;
    for (int f = 0; f < 4; f++) begin
      wait_an(8'hFE);
      lit("goal_d0", 8'hFE, goal_d0[f]);
      wait_an(8'hF7);
      lit("goal_d3", 8'hF7, goal_d3[f]);
      wait_an(8'h7F);
      lit("goal_d7", 8'h7F, goal_d7[f]);
    end

    // enter OVER while GOAL is in its dark phase
    mode = 2'd3; winner = 1'b1; score_b = 2'd3;
    for (int f = 0; f < 5; f++) begin
      wait_an(8'hFE);
      lit("over_d0", 8'hFE, over_d0[f]);
      wait_an(8'h7F);
      lit("over_d7", 8'h7F, 7'h24);
    end

    mode = 2'd1; turn = 2'b10; x_coord = 3'd1; y_coord = 3'd4;
    wait_an(8'hFE);
`ifdef HOCKEY_SSD_DP_EN
    chk("dp_turnB_d0", {7'd0, dp}, 8'd0);
`endif
    wait_an(8'hFD);
    lit("play_x1y4", 8'hFD, 7'h77);
`ifdef HOCKEY_SSD_DP_EN
    chk("dp_turnB_d1", {7'd0, dp}, 8'd1);
`endif
    wait_an(8'h7F);
    mode = 2'd2;
    wait_an(8'hFE);
`ifdef HOCKEY_SSD_DP_EN
    chk("dp_goal_d0", {7'd0, dp}, 8'd1);
`endif

    // asynchronous reset mid-frame
    wait_an(8'hFB);
    #2 rst = 1'b1;
    #1;
    lit("midrst", 8'hFF, 7'h7F);
    chk("midrst_dp", {7'd0, dp}, 8'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_an(8'hFD);
    lit("post_rst", 8'hFD, 7'h3F);
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
